// File: rtl/tpu_pkg.sv
// Shared types and dimensions for the 4x4 matrix-multiply scheduler built on the 2x2 tile engine.
package tpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      READ,
      NEXT
   } sched_state_t;

   localparam int TILE_DIM         = 2;
   localparam int MAT_DIM          = 4;
   localparam int TILE_LOAD_CYCLES = 8;
   localparam int TILE_READ_CYCLES = 4;

endpackage

// File: rtl/matmul4_scheduler_tile_index_map.sv
// Maps tile coordinates plus the in-tile step to A/B source and C target indices.
module tile_index_map (
   input  logic       ti,
   input  logic       tj,
   input  logic       tk,
   input  logic [2:0] step,
   output logic [3:0] src_idx,
   output logic [3:0] c_idx
);

   // Row-major 4x4 index is {row[1], row[0], col[1], col[0]}; tile coordinate supplies the high bit
   assign src_idx = step[2] ? {tk, step[1], tj, step[0]}
                            : {ti, step[1], tk, step[0]};
   assign c_idx   = {ti, step[1], tj, step[0]};

endmodule

// File: rtl/matmul4_scheduler.sv
// Runs a 4x4 x 4x4 byte matrix multiply as eight 2x2 tile jobs and accumulates into C.
module matmul4_scheduler
   import tpu_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       h_load_en,
   input  logic       h_load_sel_ab,
   input  logic [3:0] h_load_index,
   input  logic [7:0] h_in_data,
   input  logic       h_start,
   input  logic       h_out_en,
   input  logic [3:0] h_out_sel,
   output logic [7:0] h_out_data,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       t_load_en,
   output logic       t_load_sel_ab,
   output logic [1:0] t_load_index,
   output logic [7:0] t_in_data,
   output logic       t_out_en,
   output logic [1:0] t_out_sel,
   input  logic [7:0] t_out_data,
   input  logic       t_result_valid
);

   localparam int ELEMS  = MAT_DIM * MAT_DIM;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   sched_state_t state;
   logic [7:0]   a_mem [ELEMS];
   logic [7:0]   b_mem [ELEMS];
   logic [7:0]   c_mem [ELEMS];
   logic [15:0]  a_ld;
   logic [15:0]  b_ld;
   logic         ti, tj, tk;
   logic [2:0]   step;
   logic [WAIT_W-1:0] wait_cnt;
   logic [3:0]   src_idx;
   logic [3:0]   c_idx;
   logic         load_ok;

   assign busy    = (state != IDLE);
   assign load_ok = h_load_en && !busy;

   tile_index_map u_map (
      .ti      (ti),
      .tj      (tj),
      .tk      (tk),
      .step    (step),
      .src_idx (src_idx),
      .c_idx   (c_idx)
   );

   // Operand storage is not reset; the loaded bitmaps decide whether its contents are usable
   always_ff @(posedge clk) begin
      if (rst_n && load_ok) begin
         if (h_load_sel_ab)
            b_mem[h_load_index] <= h_in_data;
         else
            a_mem[h_load_index] <= h_in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_ld     <= '0;
         b_ld     <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         ti       <= 1'b0;
         tj       <= 1'b0;
         tk       <= 1'b0;
         step     <= '0;
         wait_cnt <= '0;
         for (int i = 0; i < ELEMS; i++)
            c_mem[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_ok) begin
                  if (h_load_sel_ab)
                     b_ld[h_load_index] <= 1'b1;
                  else
                     a_ld[h_load_index] <= 1'b1;
                  done <= 1'b0;
                  err  <= 1'b0;
               end
               // Start sees the bitmaps from before any same-cycle load
               if (h_start && (&a_ld) && (&b_ld)) begin
                  state <= LOAD;
                  ti    <= 1'b0;
                  tj    <= 1'b0;
                  tk    <= 1'b0;
                  step  <= '0;
                  done  <= 1'b0;
                  err   <= 1'b0;
               end
            end
            LOAD: begin
               if (step == 3'(TILE_LOAD_CYCLES - 1)) begin
                  state    <= WAIT;
                  step     <= '0;
                  wait_cnt <= '0;
               end else begin
                  step <= step + 3'd1;
               end
            end
            WAIT: begin
               if (t_result_valid) begin
                  state <= READ;
                  step  <= '0;
               end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  state <= IDLE;
                  err   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            READ: begin
               c_mem[c_idx] <= tk ? (c_mem[c_idx] + t_out_data) : t_out_data;
               if (step == 3'(TILE_READ_CYCLES - 1)) begin
                  state <= NEXT;
                  step  <= '0;
               end else begin
                  step <= step + 3'd1;
               end
            end
            NEXT: begin
               if (ti && tj && tk) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else begin
                  state        <= LOAD;
                  {ti, tj, tk} <= {ti, tj, tk} + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      t_load_en     = 1'b0;
      t_load_sel_ab = 1'b0;
      t_load_index  = '0;
      t_in_data     = '0;
      t_out_en      = 1'b0;
      t_out_sel     = '0;
      if (state == LOAD) begin
         t_load_en     = 1'b1;
         t_load_sel_ab = (step >= 3'(TILE_DIM * TILE_DIM));
         t_load_index  = step[1:0];
         t_in_data     = step[2] ? b_mem[src_idx] : a_mem[src_idx];
      end else if (state == READ) begin
         t_out_en  = 1'b1;
         t_out_sel = step[1:0];
      end
   end

   assign h_out_data = (h_out_en && !busy) ? c_mem[h_out_sel] : 8'd0;

endmodule

// File: tb/tb_matmul4_scheduler.sv
// Directed self-checking bench for matmul4_scheduler with a behavioural 2x2 tile-engine model.
module tb_matmul4_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       h_load_en = 1'b0;
   logic       h_load_sel_ab = 1'b0;
   logic [3:0] h_load_index = '0;
   logic [7:0] h_in_data = '0;
   logic       h_start = 1'b0;
   logic       h_out_en = 1'b0;
   logic [3:0] h_out_sel = '0;
   logic [7:0] h_out_data;
   logic       busy, done, err;
   logic       t_load_en, t_load_sel_ab;
   logic [1:0] t_load_index;
   logic [7:0] t_in_data;
   logic       t_out_en;
   logic [1:0] t_out_sel;
   logic [7:0] t_out_data;
   logic       t_result_valid;

   int checks = 0;
   int failures = 0;

   logic [7:0] a_val [16];
   logic [7:0] b_val [16];

   // Tile-engine model: latches a 2x2 A and B, raises valid model_delay cycles after the last B byte
   int         model_delay = 0;
   int         mcnt = 0;
   logic       pending = 1'b0;
   logic [7:0] ta [4];
   logic [7:0] tb [4];
   int         out_cnt = 0;
   int         load_cnt = 0;

   always #5 clk = ~clk;

   matmul4_scheduler #(.TIMEOUT(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .h_load_en      (h_load_en),
      .h_load_sel_ab  (h_load_sel_ab),
      .h_load_index   (h_load_index),
      .h_in_data      (h_in_data),
      .h_start        (h_start),
      .h_out_en       (h_out_en),
      .h_out_sel      (h_out_sel),
      .h_out_data     (h_out_data),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .t_load_en      (t_load_en),
      .t_load_sel_ab  (t_load_sel_ab),
      .t_load_index   (t_load_index),
      .t_in_data      (t_in_data),
      .t_out_en       (t_out_en),
      .t_out_sel      (t_out_sel),
      .t_out_data     (t_out_data),
      .t_result_valid (t_result_valid)
   );

   always @(posedge clk) begin
      if (t_load_en) begin
         load_cnt <= load_cnt + 1;
         if (t_load_sel_ab) tb[t_load_index] <= t_in_data;
         else               ta[t_load_index] <= t_in_data;
         if (t_load_sel_ab && t_load_index == 2'd3) begin
            pending <= 1'b1;
            mcnt    <= 0;
         end
      end else if (pending) begin
         mcnt <= mcnt + 1;
      end
      if (t_out_en) out_cnt <= out_cnt + 1;
      if (t_out_en && t_out_sel == 2'd3) pending <= 1'b0;
      if (!rst_n) pending <= 1'b0;
   end

   assign t_result_valid = pending && (mcnt >= model_delay);

   always_comb begin
      logic [7:0] p0, p1;
      p0 = 8'(ta[{t_out_sel[1], 1'b0}] * tb[{1'b0, t_out_sel[0]}]);
      p1 = 8'(ta[{t_out_sel[1], 1'b1}] * tb[{1'b1, t_out_sel[0]}]);
      t_out_data = t_out_en ? 8'(p0 + p1) : 8'd0;
   end

   task automatic load_one(input logic sel, input logic [3:0] idx, input logic [7:0] data);
      @(negedge clk);
      h_load_en = 1'b1; h_load_sel_ab = sel; h_load_index = idx; h_in_data = data;
      @(negedge clk);
      h_load_en = 1'b0;
   endtask

   task automatic load_ab();
      for (int i = 0; i < 16; i++) begin
         load_one(1'b0, 4'(i), a_val[i]);
         load_one(1'b1, 4'(i), b_val[i]);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      h_start = 1'b1;
      @(negedge clk);
      h_start = 1'b0;
   endtask

   task automatic wait_end(output int cycles);
      cycles = 0;
      while (cycles < 2000 && !done && !err) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic read_c(output logic [7:0] got [16]);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         h_out_en = 1'b1; h_out_sel = 4'(i);
         #1 got[i] = h_out_data;
      end
      h_out_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      h_out_en = 1'b1; h_out_sel = 4'd0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_status busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
      end
      checks++;
      if (t_load_en !== 1'b0 || t_out_en !== 1'b0 || t_in_data !== 8'd0 || h_out_data !== 8'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs t_load_en=%b t_out_en=%b t_in_data=%0d h_out_data=%0d expected all 0",
                  t_load_en, t_out_en, t_in_data, h_out_data);
      end
      h_out_en = 1'b0;
   endtask

   task automatic test_identity();
      int cycles;
      logic [7:0] got [16];
      for (int i = 0; i < 16; i++) begin
         a_val[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
         b_val[i] = 8'(i + 1);
      end
      load_ab();
      model_delay = 2;
      pulse_start();
      wait_end(cycles);
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL identity_status done=%b err=%b expected 1 0", done, err);
      end
      checks++;
      if (cycles !== 128) begin
         failures++;
         $display("[TB] FAIL identity_cycles got=%0d expected=128", cycles);
      end
      read_c(got);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got[i] !== 8'(i + 1)) begin
            failures++;
            $display("[TB] FAIL identity_c[%0d] got=%0d expected=%0d", i, got[i], i + 1);
         end
      end
   endtask

   task automatic test_threes_fives();
      int cycles;
      logic [7:0] got [16];
      for (int i = 0; i < 16; i++) begin
         a_val[i] = 8'd3;
         b_val[i] = 8'd5;
      end
      load_ab();
      model_delay = 0;
      pulse_start();
      wait_end(cycles);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || cycles !== 112) begin
         failures++;
         $display("[TB] FAIL threes_status done=%b err=%b cycles=%0d expected 1 0 112", done, err, cycles);
      end
      read_c(got);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got[i] !== 8'd60) begin
            failures++;
            $display("[TB] FAIL threes_c[%0d] got=%0d expected=60", i, got[i]);
         end
      end
   endtask

   task automatic test_wrap();
      int cycles;
      logic [7:0] got [16];
      for (int i = 0; i < 16; i++) begin
         a_val[i] = 8'd100;
         b_val[i] = 8'd1;
      end
      load_ab();
      model_delay = 5;
      pulse_start();
      h_out_en = 1'b1; h_out_sel = 4'd5;
      #1;
      checks++;
      if (busy !== 1'b1 || h_out_data !== 8'd0) begin
         failures++;
         $display("[TB] FAIL busy_read busy=%b h_out_data=%0d expected 1 0", busy, h_out_data);
      end
      h_out_en = 1'b0;
      wait_end(cycles);
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL wrap_status done=%b err=%b expected 1 0", done, err);
      end
      read_c(got);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (got[i] !== 8'd144) begin
            failures++;
            $display("[TB] FAIL wrap_c[%0d] got=%0d expected=144", i, got[i]);
         end
      end
   endtask

   task automatic test_timeout();
      int cycles;
      int base;
      base = out_cnt;
      model_delay = 100000;
      pulse_start();
      wait_end(cycles);
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL timeout_status err=%b done=%b busy=%b expected 1 0 0", err, done, busy);
      end
      checks++;
      if (cycles !== 24) begin
         failures++;
         $display("[TB] FAIL timeout_cycles got=%0d expected=24", cycles);
      end
      checks++;
      if (out_cnt !== base) begin
         failures++;
         $display("[TB] FAIL timeout_no_read reads=%0d expected=0", out_cnt - base);
      end
      load_one(1'b0, 4'd0, 8'd100);
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL load_clears_err err=%b done=%b expected 0 0", err, done);
      end
   endtask

   task automatic test_timeout_boundary();
      int cycles;
      logic [7:0] got [16];
      model_delay = 15;
      pulse_start();
      wait_end(cycles);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || cycles !== 232) begin
         failures++;
         $display("[TB] FAIL boundary_status done=%b err=%b cycles=%0d expected 1 0 232", done, err, cycles);
      end
      read_c(got);
      checks++;
      if (got[15] !== 8'd144) begin
         failures++;
         $display("[TB] FAIL boundary_c15 got=%0d expected=144", got[15]);
      end
   endtask

   task automatic test_unloaded_start();
      int cycles;
      logic seen_busy;
      logic [7:0] got [16];
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         load_one(1'b0, 4'(i), 8'd3);
         if (i != 15) load_one(1'b1, 4'(i), 8'd5);
      end
      pulse_start();
      seen_busy = busy;
      repeat (4) begin
         @(negedge clk);
         seen_busy = seen_busy | busy;
      end
      checks++;
      if (seen_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL start_ignored busy=%b expected 0", seen_busy);
      end
      @(negedge clk);
      h_load_en = 1'b1; h_load_sel_ab = 1'b1; h_load_index = 4'd15; h_in_data = 8'd5;
      h_start = 1'b1;
      @(negedge clk);
      h_load_en = 1'b0; h_start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL same_cycle_start busy=%b expected 0", busy);
      end
      model_delay = 1;
      pulse_start();
      wait_end(cycles);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || cycles !== 120) begin
         failures++;
         $display("[TB] FAIL unloaded_job done=%b err=%b cycles=%0d expected 1 0 120", done, err, cycles);
      end
      read_c(got);
      checks++;
      if (got[10] !== 8'd60) begin
         failures++;
         $display("[TB] FAIL unloaded_c10 got=%0d expected=60", got[10]);
      end
   endtask

   task automatic test_reset_mid_job();
      int base;
      int n;
      int loads;
      int reads;
      logic any_busy;
      base = out_cnt;
      model_delay = 3;
      pulse_start();
      n = 0;
      while (n < 2000 && !(t_out_en && (out_cnt - base) == 13)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 2000) begin
         failures++;
         $display("[TB] FAIL reach_tile3_read got=timeout expected=read of tile 3");
      end
      rst_n = 1'b0;
      @(negedge clk);
      h_out_en = 1'b1; h_out_sel = 4'd0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || t_out_en !== 1'b0 || t_load_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs busy=%b done=%b err=%b t_out_en=%b t_load_en=%b expected all 0",
                  busy, done, err, t_out_en, t_load_en);
      end
      checks++;
      if (h_out_data !== 8'd0) begin
         failures++;
         $display("[TB] FAIL midreset_c0 got=%0d expected=0", h_out_data);
      end
      h_out_en = 1'b0;
      rst_n = 1'b1;
      loads = load_cnt;
      reads = out_cnt;
      pulse_start();
      any_busy = busy;
      repeat (6) begin
         @(negedge clk);
         any_busy = any_busy | busy;
      end
      checks++;
      if (any_busy !== 1'b0 || load_cnt !== loads || out_cnt !== reads) begin
         failures++;
         $display("[TB] FAIL post_reset_start busy=%b new_loads=%0d new_reads=%0d expected 0 0 0",
                  any_busy, load_cnt - loads, out_cnt - reads);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_threes_fives();
      test_wrap();
      test_timeout();
      test_timeout_boundary();
      test_unloaded_start();
      test_reset_mid_job();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=time limit expected=bench completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/matmul4_scheduler.md
# matmul4_scheduler

Sequences a 4x4 by 4x4 8-bit matrix multiply through the existing 2x2 tile engine (the systolic-array controller). It holds the host's A and B matrices, issues eight 2x2 tile multiplies, and accumulates partial results into a 4x4 result buffer. It sits between the host byte interface and the tile engine's load/output ports.

## Interface
- `TIMEOUT`, default 16: maximum cycles to wait for `t_result_valid` per tile before aborting.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous and active-low
- `h_load_en`  in  1  host writes one byte this cycle
- `h_load_sel_ab`  in  1  0 = A, 1 = B
- `h_load_index`  in  4  row-major element index, row*4 + col
- `h_in_data`  in  8  element value
- `h_start`  in  1  start-job pulse
- `h_out_en`  in  1  host result read enable
- `h_out_sel`  in  4  result index, row-major
- `h_out_data`  out  8  result byte (combinational)
- `busy`  out  1  job in progress
- `done`  out  1  last job completed without error
- `err`  out  1  last job aborted on timeout
- `t_load_en`, `t_load_sel_ab`, `t_load_index[1:0]`, `t_in_data[7:0]`  out  tile-engine load port, same semantics as the host port at 2x2 scale
- `t_out_en`  out  1, `t_out_sel`  out  2: tile-engine result read
- `t_out_data`  in  8  tile-engine result byte, valid in the same cycle as `t_out_en`
- `t_result_valid`  in  1  tile engine is in its output phase

## Operation
- Storage: A[16], B[16], C[16] (8-bit each), plus 16-bit loaded bitmaps `a_ld` and `b_ld`.
- Host loads are accepted only when `busy` = 0. Each load writes the element and sets its bitmap bit. Loaded bits persist across jobs, so operands can be reused.
- `h_start` is accepted only when `busy` = 0 and both bitmaps are all-ones; otherwise it is ignored. An accepted start, or any host load, clears `done` and `err`.
- FSM states: IDLE, LOAD, WAIT, READ, NEXT.
  - IDLE -> LOAD on an accepted start. Tile counters ti, tj, tk are set to 0.
  - LOAD: 8 cycles with counter n = 0..7. `t_load_en` = 1.
    - n < 4: sends A tile (ti, tk), element r*2 + c = A[(2ti + r)*4 + 2tk + c], with `t_load_sel_ab` = 0 and `t_load_index` = n.
    - n >= 4: sends B tile (tk, tj), element B[(2tk + r)*4 + 2tj + c], with `t_load_sel_ab` = 1 and `t_load_index` = n - 4.
    - -> WAIT.
  - WAIT: wait counter increments each cycle.
    - -> READ when `t_result_valid` = 1.
    - If the counter reaches `TIMEOUT` first: set `err`, -> IDLE.
  - READ: 4 cycles, m = 0..3. `t_out_en` = 1, `t_out_sel` = m. The target is element (2ti + m/2, 2tj + m%2) of C.
    - tk = 0: C[target] <= `t_out_data`.
    - tk = 1: C[target] <= C[target] + `t_out_data`.
    - -> NEXT.
  - NEXT: one cycle. Advance tk, then tj, then ti, as nested counters with tk innermost. After (1, 1, 1), set `done` and go to IDLE; otherwise go to LOAD.
- Arithmetic: 8-bit modulo 256. The tile engine already truncates its results to 8 bits, and accumulation wraps.
- `busy` = (state != IDLE).
- `h_out_data` = C[`h_out_sel`] when `h_out_en` = 1 and `busy` = 0; otherwise 0.
- All `t_*` outputs are 0 outside LOAD and READ.

## Timing
- Reset (`rst_n` low at a clk edge):
  - state = IDLE.
  - Bitmaps, C, `done`, `err`, and all counters are cleared to 0.
  - All outputs are 0.
  - A reset in the middle of a job abandons it immediately. No further `t_*` activity occurs.
- Per tile: 8 (LOAD) + L (WAIT, where L is the cycle count until `t_result_valid`) + 4 (READ) + 1 (NEXT).
- Full job: 8 x (13 + L) cycles from the start edge to `done` rising.
- `done` and `err` are level outputs. They are mutually exclusive and hold until the next accepted start or host load.
- When `h_start` and `h_load_en` are asserted in the same IDLE cycle, the load is applied first. The start is evaluated against the bitmaps as they were before that load.
- `t_result_valid` seen in the same cycle the wait counter hits `TIMEOUT` counts as valid: go to READ, no error.
- Host reads during `busy` return 0.

## Structure
- Shared package `tpu_pkg`:
  - `sched_state_t` enum.
  - `TILE_DIM` = 2, `MAT_DIM` = 4, `TILE_LOAD_CYCLES` = 8, `TILE_READ_CYCLES` = 4.
- One combinational sub-module, `tile_index_map`: maps (ti, tj, tk, n or m) to the A/B source index and the C target index.

## Test plan
- A = identity, B = 1..16 row-major; start -> C = 1..16, `done` = 1, `err` = 0, total cycles = 8 x (13 + L).
- A all 3, B all 5 -> every C element = 60.
- A all 100, B all 1 -> every C element = 400 mod 256 = 144 (checks accumulation wraparound).
- Tile-engine model never raises `t_result_valid` -> `err` = 1 after 16 WAIT cycles, `busy` = 0, `done` = 0, no READ activity.
- Start with B element 15 unloaded -> ignored, `busy` stays 0. Load it, then start -> job runs.
- Assert `rst_n` low during READ of tile 3 -> next cycle IDLE, all outputs 0, bitmaps cleared, a subsequent start is ignored.
